// File: rtl/scope_capture_engine.sv
// scope_capture_engine: triggered multi-channel capture into a frame
// buffer with trigger-aligned, frame-relative readback.
//
// Ports:
//   CLK, RSTB          clock, async active-low reset
//   sample_valid/data  NCH samples per valid cycle, ch k at [k*DATA_W +: DATA_W]
//   trig_ch/level/edge trigger source, threshold, 0=rising 1=falling
//   trig_mode          00 auto, 01 normal, 10 single, 11 normal
//   pretrig            samples kept ahead of the trigger, latched at (re)arm
//   arm, frame_ack     start acquisition / renderer done with frame
//   rd_ch, rd_addr     frame-relative read request
//   rd_data            registered read data (1-cycle latency)
//   capture_done       a complete frame is held
//   triggered          one-cycle pulse per trigger event
//   trig_forced        current frame was auto-forced
//   state              FSM state code
module scope_capture_engine #(
  parameter int DATA_W = 12,
  parameter int DEPTH = 1024,
  parameter int NCH = 2,
  parameter int AUTO_SAMPLES = 65536,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  sample_valid,
  input  logic [NCH*DATA_W-1:0] sample_data,
  input  logic [CH_W-1:0]       trig_ch,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic                  trig_edge,
  input  logic [1:0]            trig_mode,
  input  logic [ADDR_W-1:0]     pretrig,
  input  logic                  arm,
  input  logic                  frame_ack,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  capture_done,
  output logic                  triggered,
  output logic                  trig_forced,
  output logic [2:0]            state
);

  localparam int AC_W = $clog2(AUTO_SAMPLES + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [AC_W-1:0] AUTO_LAST = AC_W'(AUTO_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] wr_ptr, start_ptr, rd_idx;
  logic [AC_W-1:0]   acnt_q, acnt_d;
  logic [DATA_W-1:0] prev_q, cur;
  logic              prev_ok, forced_q, trig_q;
  logic              we, fire, fire_forced, rearm;
  logic              rise, fall, hit, force_now;
  logic              is_auto, is_single;
  logic [CH_W-1:0]   rsel;

  logic [DATA_W-1:0] mem [NCH][DEPTH];

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    cur = sample_data[DATA_W-1:0];
    rsel = '0;
    for (int k = 1; k < NCH; k++) begin
      if (trig_ch == CH_W'(k))
        cur = sample_data[k*DATA_W +: DATA_W];
      if (rd_ch == CH_W'(k))
        rsel = CH_W'(k);
    end
  end

  assign is_auto = trig_mode == 2'b00;
  assign is_single = trig_mode == 2'b10;

  assign rise = prev_ok && (prev_q < trig_level)
             && (cur >= trig_level);
  assign fall = prev_ok && (prev_q >= trig_level)
             && (cur < trig_level);
  assign hit = trig_edge ? fall : rise;

  // Counter saturates, so this sample is the AUTO_SAMPLES-th in WAIT.
  assign force_now = is_auto && (acnt_q == AUTO_LAST);

  assign rd_idx = start_ptr + rd_addr;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acnt_d = acnt_q;
    we = 1'b0;
    fire = 1'b0;
    fire_forced = 1'b0;
    rearm = arm;
    if (!arm) begin
      unique case (state_q)
        IDLE: ;
        PRE: begin
          we = sample_valid;
          if (pre_q == '0) begin
            state_d = WAIT;
          end else if (sample_valid) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_d == pre_q)
              state_d = WAIT;
          end
        end
        WAIT: begin
          we = sample_valid;
          if (sample_valid) begin
            if (hit || force_now) begin
              fire = 1'b1;
              fire_forced = !hit;
              cnt_d = pre_q + ADDR_W'(1);
              // Trigger sample alone completes a max-pretrig frame.
              state_d = (pre_q == LAST) ? DONE : POST;
            end else if (acnt_q != AUTO_LAST) begin
              acnt_d = acnt_q + AC_W'(1);
            end
          end
        end
        POST: begin
          we = sample_valid;
          if (sample_valid) begin
            if (cnt_q == LAST)
              state_d = DONE;
            else
              cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        DONE: rearm = frame_ack && !is_single;
        default: state_d = IDLE;
      endcase
    end
    if (rearm) begin
      state_d = PRE;
      cnt_d = '0;
      acnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acnt_q <= '0;
      pre_q <= '0;
      wr_ptr <= '0;
      start_ptr <= '0;
      prev_q <= '0;
      prev_ok <= 1'b0;
      forced_q <= 1'b0;
      trig_q <= 1'b0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acnt_q <= acnt_d;
      trig_q <= fire;
      if (rearm) begin
        pre_q <= pretrig;
        forced_q <= 1'b0;
      end else if (fire) begin
        forced_q <= fire_forced;
      end
      if (we)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fire)
        start_ptr <= wr_ptr - pre_q;
      if (sample_valid)
        prev_q <= cur;
      // A fresh arm must not trigger off a pre-arm sample.
      if (arm)
        prev_ok <= 1'b0;
      else if (sample_valid)
        prev_ok <= 1'b1;
      rd_data <= mem[rsel][rd_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int k = 0; k < NCH; k++)
        mem[k][wr_ptr] <= sample_data[k*DATA_W +: DATA_W];
    end
  end

  assign state = state_q;
  assign capture_done = state_q == DONE;
  assign triggered = trig_q;
  assign trig_forced = forced_q;

endmodule

// File: tb/tb_scope_capture_engine.sv
// tb_scope_capture_engine: randomized acquisitions against a
// sample-history reference model, with a read-data scoreboard.
module tb_scope_capture_engine;

  localparam int DW = 12;
  localparam int DEPTH = 16;
  localparam int NCH = 2;
  localparam int AUTO = 32;

  logic          CLK = 1'b0;
  logic          RSTB = 1'b0;
  logic          sample_valid = 1'b0;
  logic [23:0]   sample_data = '0;
  logic [0:0]    trig_ch = '0;
  logic [11:0]   trig_level = '0;
  logic          trig_edge = 1'b0;
  logic [1:0]    trig_mode = 2'b01;
  logic [3:0]    pretrig = '0;
  logic          arm = 1'b0;
  logic          frame_ack = 1'b0;
  logic [0:0]    rd_ch = '0;
  logic [3:0]    rd_addr = '0;
  logic [11:0]   rd_data;
  logic          capture_done;
  logic          triggered;
  logic          trig_forced;
  logic [2:0]    state;

  scope_capture_engine #(
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .NCH(NCH),
    .AUTO_SAMPLES(AUTO)
  ) dut (
    .CLK(CLK),
    .RSTB(RSTB),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .trig_ch(trig_ch),
    .trig_level(trig_level),
    .trig_edge(trig_edge),
    .trig_mode(trig_mode),
    .pretrig(pretrig),
    .arm(arm),
    .frame_ack(frame_ack),
    .rd_ch(rd_ch),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .capture_done(capture_done),
    .triggered(triggered),
    .trig_forced(trig_forced),
    .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ch;
    int addr;
    int val;
  } rd_t;

  int   total = 0;
  int   bad = 0;
  int   trig_count = 0;
  logic rd_req = 1'b0;
  rd_t  exp_q[$];
  int   h0[$];
  int   h1[$];
  int   prev_m = 0;
  bit   prev_ok_m = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Read scoreboard: every read issued has its expected word queued.
  always @(posedge CLK) begin : rd_mon
    rd_t e;
    if (rd_req) begin
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%0d", rd_data);
      end else begin
        e = exp_q.pop_front();
        if (int'(rd_data) != e.val) begin
          bad++;
          $display("FAIL rd ch%0d addr%0d got=%0d want=%0d",
                   e.ch, e.addr, rd_data, e.val);
        end
      end
    end
  end

  always @(posedge CLK) begin : trig_mon
    #1;
    if (triggered) trig_count++;
  end

  function automatic int gen(input int kind, input int n, input int c);
    int v;
    v = 0;
    case (kind)
      0: v = (c == 0) ? n * 100 : 4000 - n * 50;
      1: begin
        v = (c == 1) ? 3000 - 200 * n : n * 7;
        if (v < 0) v = 0;
      end
      2: v = 500;
      3: v = int'($urandom_range(0, 4095));
      4: v = (c == 0) ? ((n < 52) ? n * 10 : 3000 + n) : n;
      5: v = (c == 0) ? ((n < 8) ? 100 : ((n == 8) ? 3000 : 0)) : n;
      6: v = (c == 0) ? ((n == 1) ? 0 : 3000) : n;
      default: v = 0;
    endcase
    return v;
  endfunction

  // Index of the trigger sample in the history since (re)arm: the first
  // sample past the pretrigger region that crosses the level, or, in auto
  // mode, the AUTO-th sample past that region.
  function automatic int find_trig(input logic [1:0] mode, input int p,
                                   input int lvl, input bit edg,
                                   input int tch, input bit pok,
                                   input int pv, output bit forced);
    int cur;
    int prv;
    bit ok;
    forced = 1'b0;
    for (int i = 0; i < h0.size(); i++) begin
      cur = (tch == 1) ? h1[i] : h0[i];
      if (i == 0) begin
        ok = pok;
        prv = pv;
      end else begin
        ok = 1'b1;
        prv = (tch == 1) ? h1[i-1] : h0[i-1];
      end
      if (i >= p) begin
        if (ok && (edg ? (prv >= lvl && cur < lvl)
                       : (prv < lvl && cur >= lvl)))
          return i;
        if (mode == 2'b00 && i - p == AUTO - 1) begin
          forced = 1'b1;
          return i;
        end
      end
    end
    return -1;
  endfunction

  task automatic rd(input int c, input int a, input int v);
    rd_t e;
    @(negedge CLK);
    rd_ch = c[0:0];
    rd_addr = a[3:0];
    rd_req = 1'b1;
    e.ch = c;
    e.addr = a;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic rd_end();
    @(negedge CLK);
    rd_req = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic run_acq(input bit do_arm, input logic [1:0] mode,
                         input int p, input int lvl, input bit edg,
                         input int tch, input int kind, input bit full,
                         input int max_n, output int t, output int nsamp);
    bit p0ok;
    int p0;
    int tc0;
    int d0;
    int d1;
    int idx;
    bit fexp;
    @(negedge CLK);
    trig_mode = mode;
    pretrig = p[3:0];
    trig_level = lvl[11:0];
    trig_edge = edg;
    trig_ch = tch[0:0];
    sample_valid = 1'b0;
    if (do_arm) begin
      arm = 1'b1;
      prev_ok_m = 1'b0;
    end else begin
      frame_ack = 1'b1;
    end
    @(negedge CLK);
    arm = 1'b0;
    frame_ack = 1'b0;
    chk("restart_state", int'(state), 1);
    chk("restart_done", int'(capture_done), 0);
    chk("restart_forced", int'(trig_forced), 0);
    h0.delete();
    h1.delete();
    p0ok = prev_ok_m;
    p0 = prev_m;
    tc0 = trig_count;
    nsamp = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge CLK);
      if (capture_done || nsamp >= max_n) break;
      if ($urandom_range(0, 3) != 0) begin
        d0 = gen(kind, nsamp, 0);
        d1 = gen(kind, nsamp, 1);
        sample_data = {d1[11:0], d0[11:0]};
        sample_valid = 1'b1;
        h0.push_back(d0);
        h1.push_back(d1);
        prev_m = (tch == 1) ? d1 : d0;
        prev_ok_m = 1'b1;
        nsamp++;
      end else begin
        sample_valid = 1'b0;
      end
    end
    sample_valid = 1'b0;
    t = find_trig(mode, p, lvl, edg, tch, p0ok, p0, fexp);
    if (full) begin
      chk("done", int'(capture_done), 1);
      chk("trig_pulses", trig_count - tc0, 1);
      chk("forced", int'(trig_forced), int'(fexp));
      chk("frame_len", nsamp, (t < 0) ? -1 : t + DEPTH - p);
      if (t >= 0) begin
        for (int a = 0; a < DEPTH; a++) begin
          idx = t - p + a;
          if (idx < h0.size()) begin
            rd(0, a, h0[idx]);
            rd(1, a, h1[idx]);
          end
        end
        rd_end();
      end
    end
  endtask

  initial begin
    int t;
    int n;
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_done", int'(capture_done), 0);
    chk("rst_trig", int'(triggered), 0);
    chk("rst_forced", int'(trig_forced), 0);
    chk("rst_rd", int'(rd_data), 0);
    repeat (3) @(negedge CLK);
    RSTB = 1'b1;

    // Rising edge, normal mode, ramp on ch0.
    run_acq(1, 2'b01, 4, 1000, 0, 0, 0, 1, 1000, t, n);
    chk("rise_t", t, 10);
    rd(0, 0, 600);
    rd(0, 4, 1000);
    rd(0, 15, 2100);
    rd_end();

    // Falling edge on ch1, single mode; level just above 2000 so the
    // 2000 sample is the first one strictly below it.
    run_acq(1, 2'b10, 2, 2001, 1, 1, 1, 1, 1000, t, n);
    chk("fall_t", t, 5);
    rd(1, 2, 2000);
    rd_end();
    @(negedge CLK);
    frame_ack = 1'b1;
    @(negedge CLK);
    frame_ack = 1'b0;
    repeat (2) @(negedge CLK);
    chk("single_ack_state", int'(state), 4);
    chk("single_ack_done", int'(capture_done), 1);

    // Auto mode, flat input: forced trigger, then rearm by frame_ack.
    run_acq(1, 2'b00, 0, 1000, 0, 0, 2, 1, 1000, t, n);
    chk("auto_t", t, AUTO - 1);
    run_acq(0, 2'b00, 0, 2048, 0, 0, 3, 1, 1000, t, n);

    // Maximum pretrigger with a long wait across the pointer wrap.
    run_acq(1, 2'b01, 15, 2000, 0, 0, 4, 1, 1000, t, n);
    chk("wrap_t", t, 52);
    rd(0, 15, 3052);
    rd(0, 0, 370);
    rd_end();

    // Arm mid-POST; the first post-arm sample must not trigger.
    run_acq(1, 2'b01, 2, 2000, 0, 0, 5, 0, 12, t, n);
    chk("abort_post_state", int'(state), 3);
    run_acq(1, 2'b01, 0, 2000, 0, 0, 6, 1, 1000, t, n);
    chk("abort_t", t, 2);

    // Reset mid-POST.
    run_acq(1, 2'b01, 4, 1000, 0, 0, 0, 0, 14, t, n);
    chk("rst_post_state", int'(state), 3);
    @(negedge CLK);
    #2;
    RSTB = 1'b0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_done", int'(capture_done), 0);
    chk("midrst_trig", int'(triggered), 0);
    chk("midrst_rd", int'(rd_data), 0);
    @(negedge CLK);
    RSTB = 1'b1;
    prev_ok_m = 1'b0;

    // Random auto-mode acquisitions.
    repeat (6) begin
      run_acq(1, 2'b00, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), 3, 1, 1000, t, n);
    end

    chk("rd_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
